// File: rtl/lvdt_pkg.sv
// Shared types and sizing for the LVDT phase calibration logic.
// Provides the sweep FSM state encoding and the magnitude accumulator width helper.
package lvdt_pkg;

  localparam int PHASE_W_DEF  = 8;
  localparam int SAMPLE_W_DEF = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_SETTLE  = 3'd1;
  localparam state_t S_ACCUM   = 3'd2;
  localparam state_t S_COMPARE = 3'd3;
  localparam state_t S_STEP    = 3'd4;
  localparam state_t S_APPLY   = 3'd5;

  // The absolute value is saturated, so 2^nsamp_log2 magnitudes fit without overflow.
  function automatic int mag_w(input int sample_w, input int nsamp_log2);
    return sample_w + nsamp_log2;
  endfunction

endpackage

// File: rtl/lvdt_mag_accum.sv
// Saturating |sample| accumulator over 2^NSAMP_LOG2 qualified samples.
// full is combinational and marks the edge on which the last sample is added.
module lvdt_mag_accum
  import lvdt_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int NSAMP_LOG2 = 4,
  localparam int MAG_W     = mag_w(SAMPLE_W, NSAMP_LOG2)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic                en,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [MAG_W-1:0]    acc,
  output logic                full
);

  localparam int CNT_W = (NSAMP_LOG2 > 0) ? NSAMP_LOG2 : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'((1 << NSAMP_LOG2) - 1);
  localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] mag;
  logic                take;

  // Most-negative input has no positive twin; clamp it to full-scale positive.
  always_comb begin
    mag = sample_data;
    if (sample_data == MOST_NEG)
      mag = MOST_POS;
    else if (sample_data[SAMPLE_W-1])
      mag = -sample_data;
  end

  assign take = en & sample_valid;
  assign full = take & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      acc <= acc + MAG_W'(mag);
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lvdt_phase_sweep_ctrl.sv
// LVDT demod phase auto-calibration: sweeps phase, keeps the max-magnitude point, applies it.
// Define LVDT_PHASE_FINE_EN to add a step-1 fine pass around the coarse best before applying.
module lvdt_phase_sweep_ctrl
  import lvdt_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int SETTLE_CYC = 1024,
  parameter int NSAMP_LOG2 = 4,
  parameter int STEP       = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           cpu_wr,
  input  logic [PHASE_W-1:0]             cpu_phase,
  input  logic                           sample_valid,
  input  logic [SAMPLE_W-1:0]            sample_data,
  output logic [PHASE_W-1:0]             phase_out,
  output logic                           busy,
  output logic                           done,
  output logic [PHASE_W-1:0]             best_phase,
  output logic [SAMPLE_W+NSAMP_LOG2-1:0] best_mag
);

  localparam int MAG_W  = mag_w(SAMPLE_W, NSAMP_LOG2);
  localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SCNT_W-1:0]  SETTLE_LOAD = SCNT_W'(SETTLE_CYC - 1);
  localparam logic [PHASE_W:0]   STEP_EXT    = (PHASE_W+1)'(STEP);

  state_t             state;
  logic [PHASE_W-1:0] restore_phase;
  logic [PHASE_W-1:0] run_best_phase;
  logic [MAG_W-1:0]   run_best_mag;
  logic [MAG_W-1:0]   acc;
  logic [SCNT_W-1:0]  settle_cnt;
  logic               acc_clr;
  logic               acc_en;
  logic               acc_full;
  logic [PHASE_W:0]   next_coarse;
  logic               better;

  assign busy        = (state != S_IDLE);
  assign acc_clr     = (state == S_SETTLE) && (settle_cnt == '0);
  assign acc_en      = (state == S_ACCUM);
  assign next_coarse = {1'b0, phase_out} + STEP_EXT;
  // Equal magnitudes only move the best toward a lower phase.
  assign better = (acc > run_best_mag) ||
                  ((acc == run_best_mag) && (phase_out < run_best_phase));

`ifdef LVDT_PHASE_FINE_EN
  localparam logic [PHASE_W:0] REACH = (PHASE_W+1)'(STEP - 1);
  localparam logic [PHASE_W:0] PMAX  = {1'b0, {PHASE_W{1'b1}}};

  logic               fine;
  logic [PHASE_W-1:0] fine_end;
  logic [PHASE_W:0]   best_ext;
  logic [PHASE_W:0]   fine_lo;
  logic [PHASE_W:0]   fine_hi;

  assign best_ext = {1'b0, run_best_phase};
  assign fine_lo  = (best_ext > REACH) ? (best_ext - REACH) : '0;
  assign fine_hi  = ((best_ext + REACH) > PMAX) ? PMAX : (best_ext + REACH);
`endif

  lvdt_mag_accum #(
    .SAMPLE_W   (SAMPLE_W),
    .NSAMP_LOG2 (NSAMP_LOG2)
  ) u_mag_accum (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr          (acc_clr),
    .en           (acc_en),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .acc          (acc),
    .full         (acc_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      phase_out      <= '0;
      restore_phase  <= '0;
      run_best_phase <= '0;
      run_best_mag   <= '0;
      settle_cnt     <= '0;
      best_phase     <= '0;
      best_mag       <= '0;
      done           <= 1'b0;
`ifdef LVDT_PHASE_FINE_EN
      fine           <= 1'b0;
      fine_end       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (busy && abort) begin
        phase_out <= restore_phase;
        state     <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              restore_phase  <= phase_out;
              phase_out      <= '0;
              run_best_phase <= '0;
              run_best_mag   <= '0;
              settle_cnt     <= SETTLE_LOAD;
              state          <= S_SETTLE;
`ifdef LVDT_PHASE_FINE_EN
              fine           <= 1'b0;
`endif
            end else if (cpu_wr) begin
              phase_out <= cpu_phase;
            end
          end
          S_SETTLE: begin
            if (settle_cnt == '0)
              state <= S_ACCUM;
            else
              settle_cnt <= settle_cnt - 1'b1;
          end
          S_ACCUM: begin
            if (acc_full)
              state <= S_COMPARE;
          end
          S_COMPARE: begin
            if (better) begin
              run_best_mag   <= acc;
              run_best_phase <= phase_out;
            end
            state <= S_STEP;
          end
          S_STEP: begin
`ifdef LVDT_PHASE_FINE_EN
            if (fine) begin
              if (phase_out >= fine_end) begin
                state <= S_APPLY;
              end else begin
                phase_out  <= phase_out + 1'b1;
                settle_cnt <= SETTLE_LOAD;
                state      <= S_SETTLE;
              end
            end else if (next_coarse[PHASE_W]) begin
              fine       <= 1'b1;
              phase_out  <= fine_lo[PHASE_W-1:0];
              fine_end   <= fine_hi[PHASE_W-1:0];
              settle_cnt <= SETTLE_LOAD;
              state      <= S_SETTLE;
            end else begin
              phase_out  <= next_coarse[PHASE_W-1:0];
              settle_cnt <= SETTLE_LOAD;
              state      <= S_SETTLE;
            end
`else
            if (next_coarse[PHASE_W]) begin
              state <= S_APPLY;
            end else begin
              phase_out  <= next_coarse[PHASE_W-1:0];
              settle_cnt <= SETTLE_LOAD;
              state      <= S_SETTLE;
            end
`endif
          end
          S_APPLY: begin
            phase_out  <= run_best_phase;
            best_phase <= run_best_phase;
            best_mag   <= run_best_mag;
            done       <= 1'b1;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lvdt_phase_sweep_ctrl.sv
// Directed bench for lvdt_phase_sweep_ctrl with a phase-dependent demod sample model.
// Expected results are hand-computed and hold with or without LVDT_PHASE_FINE_EN.
module tb_lvdt_phase_sweep_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        cpu_wr;
  logic [7:0]  cpu_phase;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [7:0]  phase_out;
  logic        busy;
  logic        done;
  logic [7:0]  best_phase;
  logic [17:0] best_mag;

  int n_checks;
  int n_fail;
  int mode;
  logic [7:0] ph_q[$];

  lvdt_phase_sweep_ctrl #(
    .PHASE_W    (8),
    .SAMPLE_W   (16),
    .SETTLE_CYC (4),
    .NSAMP_LOG2 (2),
    .STEP       (64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .cpu_wr       (cpu_wr),
    .cpu_phase    (cpu_phase),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .phase_out    (phase_out),
    .busy         (busy),
    .done         (done),
    .best_phase   (best_phase),
    .best_mag     (best_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int model_mag(input int m, input logic [7:0] p);
    int d;
    case (m)
      1: begin
        case (p)
          8'd0:    return 100;
          8'd64:   return 900;
          8'd128:  return 300;
          8'd192:  return 50;
          default: return 0;
        endcase
      end
      2: return 500;
      6: begin
        d = (p > 8'd70) ? (int'(p) - 70) * 10 : (70 - int'(p)) * 10;
        return (d >= 2000) ? 0 : 2000 - d;
      end
      default: return 0;
    endcase
  endfunction

  // Demod model: two valid samples out of every three cycles, alternating sign.
  initial begin
    int vcnt;
    int m;
    logic neg;
    vcnt = 0;
    neg = 1'b0;
    sample_valid = 1'b0;
    sample_data = '0;
    forever begin
      @(negedge clk);
      vcnt = (vcnt + 1) % 3;
      sample_valid = (vcnt != 0);
      if (mode == 4) begin
        sample_data = (phase_out == 8'd0) ? 16'h8000 : 16'h0000;
      end else begin
        m = model_mag(mode, phase_out);
        sample_data = neg ? 16'(-m) : 16'(m);
      end
      if (sample_valid) neg = ~neg;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    ph_q.delete();
    for (int i = 0; i < 6000; i++) begin
      if (busy && (ph_q.size() == 0 || ph_q[$] != phase_out)) ph_q.push_back(phase_out);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_phase(input string tag, input logic [7:0] p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (phase_out == p) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check_eq({tag, "_phase_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n_done;
    n_checks = 0;
    n_fail = 0;
    mode = 0;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cpu_wr = 1'b0;
    cpu_phase = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_phase_out", phase_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_best_phase", best_phase, 0);
    check_eq("rst_best_mag", best_mag, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: distinct peak at 64
    mode = 1;
    pulse_start();
    check_eq("t1_busy_after_start", busy, 1);
    wait_done("t1");
    check_eq("t1_visit0", ph_q[0], 0);
    check_eq("t1_visit1", ph_q[1], 64);
    check_eq("t1_visit2", ph_q[2], 128);
    check_eq("t1_visit3", ph_q[3], 192);
    check_eq("t1_phase_out", phase_out, 64);
    check_eq("t1_best_phase", best_phase, 64);
    check_eq("t1_best_mag", best_mag, 3600);
    @(negedge clk);
    check_eq("t1_done_width", done, 0);

    // 2: all equal, lowest phase wins
    mode = 2;
    pulse_start();
    check_eq("t2_phase_zeroed", phase_out, 0);
    wait_done("t2");
    check_eq("t2_busy_with_done", busy, 0);
    check_eq("t2_best_phase", best_phase, 0);
    check_eq("t2_best_mag", best_mag, 2000);
    check_eq("t2_phase_out", phase_out, 0);
    @(negedge clk);
    check_eq("t2_done_width", done, 0);

    // 3: CPU write, idle abort, mid-sweep abort
    mode = 1;
    cpu_wr = 1'b1;
    cpu_phase = 8'h37;
    @(negedge clk);
    cpu_wr = 1'b0;
    check_eq("t3_cpu_wr", phase_out, 8'h37);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t3_idle_abort_phase", phase_out, 8'h37);
    check_eq("t3_idle_abort_busy", busy, 0);
    pulse_start();
    wait_phase("t3", 8'd128);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t3_abort_restore", phase_out, 8'h37);
    check_eq("t3_abort_busy", busy, 0);
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check_eq("t3_no_done", n_done, 0);
    check_eq("t3_best_phase_kept", best_phase, 0);
    check_eq("t3_best_mag_kept", best_mag, 2000);

    // 4: most-negative samples saturate
    mode = 4;
    pulse_start();
    wait_done("t4");
    check_eq("t4_best_phase", best_phase, 0);
    check_eq("t4_best_mag", best_mag, 131068);
    check_eq("t4_phase_out", phase_out, 0);

    // 5: start/cpu_wr ignored while busy; start beats cpu_wr in idle
    mode = 1;
    pulse_start();
    repeat (8) @(negedge clk);
    start = 1'b1;
    cpu_wr = 1'b1;
    cpu_phase = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    cpu_wr = 1'b0;
    check_eq("t5_cpu_wr_ignored", phase_out == 8'hAA, 0);
    check_eq("t5_still_busy", busy, 1);
    wait_done("t5");
    check_eq("t5_phase_out", phase_out, 64);
    check_eq("t5_best_mag", best_mag, 3600);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy || done) n_done++;
    end
    check_eq("t5_no_restart", n_done, 0);
    start = 1'b1;
    cpu_wr = 1'b1;
    cpu_phase = 8'h55;
    @(negedge clk);
    start = 1'b0;
    cpu_wr = 1'b0;
    check_eq("t5_same_cycle_busy", busy, 1);
    check_eq("t5_same_cycle_phase", phase_out, 0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t5_restore_pre_start", phase_out, 64);

`ifdef LVDT_PHASE_FINE_EN
    // 6: fine pass finds the off-grid peak
    mode = 6;
    pulse_start();
    wait_done("t6");
    check_eq("t6_coarse_last", ph_q[3], 192);
    check_eq("t6_fine_first", ph_q[4], 1);
    check_eq("t6_fine_last", ph_q[$], 127);
    check_eq("t6_visit_count", ph_q.size(), 131);
    check_eq("t6_phase_out", phase_out, 70);
    check_eq("t6_best_phase", best_phase, 70);
    check_eq("t6_best_mag", best_mag, 8000);
    @(negedge clk);
`endif

    // async reset during a sweep
    mode = 1;
    pulse_start();
    wait_phase("t7", 8'd64);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t7_arst_phase_out", phase_out, 0);
    check_eq("t7_arst_busy", busy, 0);
    check_eq("t7_arst_best_phase", best_phase, 0);
    check_eq("t7_arst_best_mag", best_mag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvdt_phase_sweep_ctrl.md
Name: lvdt_phase_sweep_ctrl

Overview:
- Auto-calibration sequencer for the LVDT demodulator phase setting.
- On request, steps the 8-bit demod phase across its range and lets the demod settle at each point.
- At each point, accumulates the magnitude of demodulated samples and keeps the phase giving the largest magnitude, then applies it.
- Sits between the CPU's phase PIO write path and the demodulator phase input. The CPU can still set phase directly when no sweep is running.

Parameters:
- PHASE_W, 8: phase setting width.
- SAMPLE_W, 16: signed demod sample width.
- SETTLE_CYC, 1024: clk cycles waited after each phase change before sampling; must be >= 1.
- NSAMP_LOG2, 4: log2 of the number of valid samples accumulated per phase point.
- STEP, 4: coarse sweep increment; power of two, 1..2^(PHASE_W-1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle sweep request
- abort  in  1  one-cycle sweep cancel
- cpu_wr  in  1  CPU direct phase write strobe
- cpu_phase  in  PHASE_W  CPU phase value
- sample_valid  in  1  demod sample qualifier
- sample_data  in  SAMPLE_W  signed demod output
- phase_out  out  PHASE_W  phase applied to the demodulator
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on sweep completion
- best_phase  out  PHASE_W  phase selected by the last completed sweep
- best_mag  out  SAMPLE_W+NSAMP_LOG2  accumulated magnitude at best_phase

Behaviour:
- Reset: all outputs 0; FSM in IDLE.
- FSM states: IDLE, SETTLE, ACCUM, COMPARE, STEP, APPLY.
- IDLE:
  - cpu_wr loads phase_out from cpu_phase on the next edge.
  - start (sampled in IDLE only) saves phase_out into a restore register, sets phase_out=0, clears the running best, loads the settle counter with SETTLE_CYC-1, sets busy, and goes to SETTLE.
  - If start and cpu_wr are asserted together, start wins and cpu_wr is dropped.
- SETTLE: counter decrements once per cycle; samples are ignored. At 0, clear the accumulator and sample counter, then go to ACCUM.
- ACCUM:
  - Each sample_valid adds |sample_data| to the accumulator (zero-extended to SAMPLE_W+NSAMP_LOG2).
  - The most-negative sample_data value gives magnitude 2^(SAMPLE_W-1)-1 (saturate), so the accumulator never overflows.
  - After 2^NSAMP_LOG2 valid samples, go to COMPARE. There is no timeout: absent sample_valid holds the FSM in ACCUM.
- COMPARE: if accumulator > running best (strict), update best value and best phase. Ties keep the lower phase. Go to STEP (1 cycle).
- STEP: if phase_out + STEP exceeds 2^PHASE_W-1, go to APPLY. Otherwise phase_out += STEP, reload the settle counter, go to SETTLE.
- APPLY:
  - phase_out <= running best phase; best_phase/best_mag registers <= running best.
  - done=1 for exactly this cycle; busy deasserts on the same edge; FSM returns to IDLE.
- busy is 1 in every non-IDLE state.
- Ignored while busy: start, and cpu_wr (the CPU value is not queued).
- abort in any busy state:
  - phase_out <= restore register; FSM goes to IDLE next edge.
  - No done pulse; best_phase/best_mag keep their previous values.
  - abort has priority over every other transition in the same cycle; abort in IDLE does nothing.
- Asynchronous reset mid-sweep: all registers return to 0 immediately.
- Latency per point: SETTLE_CYC + (cycles to collect 2^NSAMP_LOG2 samples) + 2 (COMPARE, STEP).

Optional Feature:
- Macro: LVDT_PHASE_FINE_EN.
- Defined:
  - After the coarse sweep, APPLY is replaced by a fine pass over best-(STEP-1) .. best+(STEP-1) at step 1, clamped to 0 .. 2^PHASE_W-1.
  - The fine pass reuses SETTLE/ACCUM/COMPARE and keeps the best from both passes.
  - APPLY then runs as above.
  - Adds a FINE flag bit and a fine end-limit register.
- Undefined: coarse sweep only; no fine-pass logic is synthesized.

Decomposition:
- Shared package lvdt_pkg holds:
  - the FSM state enum;
  - PHASE_W and SAMPLE_W defaults;
  - a magnitude-width constant function (SAMPLE_W+NSAMP_LOG2).
- One sub-module, lvdt_mag_accum: saturating absolute value plus accumulator plus sample counter, with clear/enable/full signals. It is reusable by other demod channels.
- The FSM and phase/restore registers stay in the top module.

Test Plan:
Bench parameters: SETTLE_CYC=4, NSAMP_LOG2=2, STEP=64 (phase points 0, 64, 128, 192).
1. Sample model returns |s| = 100, 900, 300, 50 at the four phases; start -> phase_out visits 0/64/128/192, then done pulse; phase_out=64, best_phase=64, best_mag=3600.
2. All points return 500 (tie) -> best_phase=0, best_mag=2000; done exactly 1 cycle; busy low the same cycle done is high.
3. cpu_wr cpu_phase=0x37 in IDLE, then start, then abort while phase_out=128 -> phase_out returns to 0x37 the next cycle; no done pulse; best_phase unchanged.
4. sample_data=0x8000 for all samples at phase 0, 0 elsewhere -> per-sample magnitude 32767; best_mag=131068, best_phase=0.
5. cpu_wr pulses and a second start during the sweep -> ignored; sweep completes normally. start and cpu_wr in the same IDLE cycle -> sweep starts, phase_out=0.
6. With LVDT_PHASE_FINE_EN defined, peak placed at phase 70 -> coarse best 64; fine pass covers 1..127; final phase_out=70.
